// File: rtl/ram_loader.sv
`timescale 1ns/1ps
// ram_loader
//   Fills a synchronous 32-bit RAM from a byte stream, then verifies it.
//   Every four accepted bytes are packed MSB first into one word. WORDS words
//   go to RAM addresses 0..WORDS-1. The loader then reads every word back and
//   compares the read-back sum with the sum of the written words.
//
// Ports
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   start         one-cycle run request, honoured only in IDLE
//   byte_in       stream data byte
//   byte_valid    byte_in carries data this cycle
//   byte_ready    loader can take a byte this cycle
//   ram_ena       RAM enable (WRITE and RD_ISSUE only)
//   ram_wena      RAM write enable (1 = write, 0 = read)
//   ram_addr      RAM address; holds its last value while ram_ena=0
//   ram_wdata     RAM write data; holds its last value outside WRITE
//   ram_rdata     RAM read data, valid the cycle after a read is issued
//   busy          high from the cycle after start is accepted until done
//   done          level, set when a run completes, cleared by the next start
//   error         valid while done=1: read-back sum differs from write sum
//   checksum      32-bit wrapping sum of the written words
//
// Stream handshake: a byte moves on a rising edge where byte_valid and
// byte_ready are both 1. byte_ready depends only on the FSM state, never on
// byte_valid, and byte_valid may drop at any cycle without losing data.
//
// The FSM state register (state_q) is left visible for checkers to bind to.

module ram_loader #(
  parameter int ADDR_W = 5,
  parameter int WORDS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WRITE    = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_CAPT  = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        cnt_q;
  logic [31:0]       word_q;
  logic [31:0]       sum_q;
  logic [31:0]       rsum_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              last_idx;

  assign last_idx = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and RAM / stream strobes
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    ram_ena    = 1'b0;
    ram_wena   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid && (cnt_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        ram_ena  = 1'b1;
        ram_wena = 1'b1;
        state_d  = last_idx ? S_RD_ISSUE : S_LOAD;
      end
      S_RD_ISSUE: begin
        ram_ena = 1'b1;
        state_d = S_RD_CAPT;
      end
      S_RD_CAPT: begin
        state_d = last_idx ? S_FINISH : S_RD_ISSUE;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address and write data show the live index/word only while the RAM is
  // being driven; otherwise they replay the value captured last cycle.
  assign ram_addr  = (state_q == S_WRITE || state_q == S_RD_ISSUE) ? idx_q : addr_q;
  assign ram_wdata = (state_q == S_WRITE) ? word_q : wdata_q;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      sum_q   <= '0;
      rsum_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            rsum_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            // Shift left so the first byte ends up in bits [31:24].
            word_q <= {word_q[23:0], byte_in};
            cnt_q  <= cnt_q + 2'd1;
          end
        end
        S_WRITE: begin
          sum_q <= sum_q + word_q;
          idx_q <= last_idx ? '0 : idx_q + ADDR_W'(1);
        end
        S_RD_CAPT: begin
          rsum_q <= rsum_q + ram_rdata;
          if (!last_idx) idx_q <= idx_q + ADDR_W'(1);
        end
        S_FINISH: begin
          error_q <= (rsum_q != sum_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign checksum = sum_q;

endmodule

// File: tb/tb_ram_loader.sv
`timescale 1ns/1ps
// tb_ram_loader
//   Directed bench for ram_loader: a WORDS=32 instance (dut0) and a WORDS=1
//   instance (dut1), each with its own synchronous RAM model. Expected RAM
//   writes are queued as bytes are fed and popped when the write appears.

module tb_ram_loader;

  localparam int AW = 5;
  localparam int NW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- dut0 (WORDS=32) ----------------
  logic          start, byte_valid, byte_ready;
  logic [7:0]    byte_in;
  logic          ram_ena, ram_wena, busy, done, error;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, checksum;
  logic [31:0]   ram_rdata = '0;

  ram_loader #(.ADDR_W(AW), .WORDS(NW)) dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .ram_ena(ram_ena),
    .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  // ---------------- dut1 (WORDS=1) ----------------
  logic          start1, byte_valid1, byte_ready1;
  logic [7:0]    byte_in1;
  logic          ram_ena1, ram_wena1, busy1, done1, error1;
  logic [AW-1:0] ram_addr1;
  logic [31:0]   ram_wdata1, checksum1;
  logic [31:0]   ram_rdata1 = '0;

  ram_loader #(.ADDR_W(AW), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .byte_in(byte_in1),
    .byte_valid(byte_valid1), .byte_ready(byte_ready1), .ram_ena(ram_ena1),
    .ram_wena(ram_wena1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1), .busy(busy1), .done(done1), .error(error1),
    .checksum(checksum1)
  );

  // ---------------- RAM models ----------------
  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];
  bit          corrupt = 1'b0;

  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wena) mem0[ram_addr] <= ram_wdata;
      else ram_rdata <= mem0[ram_addr] ^ ((corrupt && ram_addr == 5'd5) ? 32'h1 : 32'h0);
    end
    if (ram_ena1) begin
      if (ram_wena1) mem1[ram_addr1] <= ram_wdata1;
      else ram_rdata1 <= mem1[ram_addr1];
    end
  end

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];   // {addr, word}
  logic [31:0] exp_sum;
  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  int writes = 0;
  int writes1 = 0;
  logic [AW-1:0] last_a1 = '0;
  logic [31:0]   last_w1 = '0;
  int cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (byte_valid && byte_ready) xfers++;
    if (ram_ena && ram_wena) begin
      writes++;
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL wr_unexpected: observed write addr %0d data 0x%0h, expected none",
               ram_addr, ram_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ram_addr), 64'(e[36:32]));
        check("wr_data", 64'(ram_wdata), 64'(e[31:0]));
      end
    end
    if (ram_ena1 && ram_wena1) begin
      writes1++;
      last_a1 = ram_addr1;
      last_w1 = ram_wdata1;
    end
  end

  // ---------------- driver tasks ----------------
  // Feeds nbytes incrementing from 'first'. In stall mode each byte is
  // preceded by one cycle with byte_valid=0 while byte_ready=1.
  task automatic feed(input int nbytes, input bit stall, input int first);
    logic [31:0] w;
    int g;
    w = '0;
    for (int i = 0; i < nbytes; i++) begin
      g = 0;
      if (stall) begin
        byte_valid = 1'b0;
        while (!byte_ready && g < 2000) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
      end
      byte_in    = 8'(first + i);
      byte_valid = 1'b1;
      while (!byte_ready && g < 2000) begin @(posedge clk); #1; g++; end
      if (g >= 2000) check("feed_timeout", 64'(g), 64'(0));
      @(posedge clk); #1;
      w = {w[23:0], 8'(first + i)};
      if (i % 4 == 3) begin
        exp_q.push_back({5'(i / 4), w});
        exp_sum = exp_sum + w;
      end
    end
  endtask

  task automatic run(input bit stall, input bit pulse, output int cycles);
    int g;
    exp_sum = '0;
    xfers   = 0;
    writes  = 0;
    cycles  = 0;
    fork
      feed(4 * NW, stall, 0);
      begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_clears_done", 64'({done, error, busy}), 64'(3'b001));
        while (!done && cycles < 5000) begin @(posedge clk); #1; cycles++; end
      end
      if (pulse) begin
        g = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        while (!byte_ready && g < 100) begin @(posedge clk); #1; g++; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(ram_ena && !ram_wena) && g < 2000) begin @(posedge clk); #1; g++; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    byte_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] bw;
    int g;
    rst = 1'b1; start = 1'b0; byte_in = '0; byte_valid = 1'b0;
    start1 = 1'b0; byte_in1 = '0; byte_valid1 = 1'b0;
    exp_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({byte_ready, ram_ena, ram_wena, busy, done, error, ram_addr}), 64'(0));
    check("reset_data", {ram_wdata, checksum}, 64'(0));
    check("reset_ctrl1", 64'({byte_ready1, ram_ena1, busy1, done1, error1, ram_addr1}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of LOAD, after 6 accepted bytes.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(6, 1'b0, 8'h40);
    check("midload_busy", 64'({busy, byte_ready, checksum}), {31'd0, 2'b11, 32'h40414243});
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", 64'({byte_ready, ram_ena, ram_wena, busy, done, error, ram_addr}), 64'(0));
    check("rst_async_data", {ram_wdata, checksum}, 64'(0));
    byte_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_state", 64'({dut0.state_q, byte_ready}), 64'(0));
    check("rst_writes", 64'(writes), 64'(1));
    exp_q.delete();

    // Full run, continuous valid.
    run(1'b0, 1'b0, cyc);
    check("full_cycles", 64'(cyc), 64'(225));
    check("full_checksum", 64'(checksum), 64'(exp_sum));
    check("full_flags", 64'({done, error, busy}), 64'(3'b100));
    check("full_xfers", 64'(xfers), 64'(4 * NW));
    check("full_writes", 64'(writes), 64'(NW));
    check("full_q_empty", 64'(exp_q.size()), 64'(0));
    check("full_mem31", 64'(mem0[31]), 64'(32'h7C7D7E7F));

    // Stalled stream: one idle cycle before every byte, 9 cycles per word.
    run(1'b1, 1'b0, cyc);
    check("stall_cycles", 64'(cyc), 64'(1 + 9 * NW + 2 * NW));
    check("stall_checksum", 64'(checksum), 64'(exp_sum));
    check("stall_flags", 64'({done, error, busy}), 64'(3'b100));
    check("stall_writes", 64'(writes), 64'(NW));
    check("stall_q_empty", 64'(exp_q.size()), 64'(0));

    // Corrupted read-back of word 5.
    corrupt = 1'b1;
    run(1'b0, 1'b0, cyc);
    corrupt = 1'b0;
    check("corrupt_cycles", 64'(cyc), 64'(225));
    check("corrupt_checksum", 64'(checksum), 64'(exp_sum));
    check("corrupt_flags", 64'({done, error, busy}), 64'(3'b110));

    // start pulses during LOAD and RD_ISSUE, valid held through verify.
    run(1'b0, 1'b1, cyc);
    check("ignore_cycles", 64'(cyc), 64'(225));
    check("ignore_xfers", 64'(xfers), 64'(4 * NW));
    check("ignore_writes", 64'(writes), 64'(NW));
    check("ignore_flags", 64'({done, error, busy}), 64'(3'b100));
    check("ignore_q_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
    check("ignore_idle", 64'({dut0.state_q, busy}), 64'(0));

    // WORDS=1 instance.
    bw = 32'hDEADBEEF;
    cyc = 0;
    fork
      begin
        byte_valid1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
          g = 0;
          byte_in1 = bw[31 - 8 * i -: 8];
          while (!byte_ready1 && g < 100) begin @(posedge clk); #1; g++; end
          @(posedge clk); #1;
        end
        byte_valid1 = 1'b0;
      end
      begin
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        while (!done1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
      end
    join
    check("w1_cycles", 64'(cyc), 64'(8));
    check("w1_writes", 64'(writes1), 64'(1));
    check("w1_write", {27'd0, last_a1, last_w1}, {27'd0, 5'd0, 32'hDEADBEEF});
    check("w1_checksum", 64'(checksum1), 64'(32'hDEADBEEF));
    check("w1_flags", 64'({done1, error1, busy1}), 64'(3'b100));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
